// File: rtl/decode_stage.sv
// RV32I decode stage: registers decoded fields for execute, inserts a one-cycle
// bubble on load-use hazards and back-pressures fetch through ds_o_stall.
module decode_stage #(
  parameter int IWIDTH     = 32,
  parameter int PC_WIDTH   = 32,
  parameter int AWIDTH_REG = 5,
  parameter int DWIDTH     = 32
) (
  input  logic                  ds_clk,
  input  logic                  ds_rst,
  input  logic [IWIDTH-1:0]     ds_i_instr,
  input  logic [PC_WIDTH-1:0]   ds_i_pc,
  input  logic                  ds_i_ce,
  input  logic                  ds_i_stall,
  input  logic                  ds_i_flush,
  output logic                  ds_o_stall,
  output logic                  ds_o_flush,
  output logic                  ds_o_ce,
  output logic [PC_WIDTH-1:0]   ds_o_pc,
  output logic [AWIDTH_REG-1:0] ds_o_rs1,
  output logic [AWIDTH_REG-1:0] ds_o_rs2,
  output logic [AWIDTH_REG-1:0] ds_o_rd,
  output logic [DWIDTH-1:0]     ds_o_imm,
  output logic [2:0]            ds_o_funct3,
  output logic                  ds_o_funct7b5,
  output logic [10:0]           ds_o_class,
  output logic                  ds_o_illegal
);

  // Handshake: ds_i_ce qualifies ds_i_instr/ds_i_pc for the coming edge and ds_o_ce
  // qualifies the registered fields. Fetch must hold its instruction while ds_o_stall=1.

  localparam int C_RALU   = 0;
  localparam int C_IALU   = 1;
  localparam int C_LOAD   = 2;
  localparam int C_STORE  = 3;
  localparam int C_BRANCH = 4;
  localparam int C_JAL    = 5;
  localparam int C_JALR   = 6;
  localparam int C_LUI    = 7;
  localparam int C_AUIPC  = 8;
  localparam int C_SYSTEM = 9;
  localparam int C_FENCE  = 10;

  logic                  ce_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [AWIDTH_REG-1:0] rs1_q, rs2_q, rd_q;
  logic [DWIDTH-1:0]     imm_q;
  logic [2:0]            funct3_q;
  logic                  funct7b5_q;
  logic [10:0]           class_q;
  logic                  illegal_q;

  logic [10:0]           class_d;
  logic [DWIDTH-1:0]     imm_d;
  logic [AWIDTH_REG-1:0] rs1_d, rs2_d, rd_d;
  logic                  illegal_d;
  logic signed [31:0]    imm32;
  logic [6:0]            opcode;
  logic                  s;
  logic                  rs1_used, rs2_used, hazard;

  assign opcode = ds_i_instr[6:0];
  assign s      = ds_i_instr[31];
  assign rs1_d  = AWIDTH_REG'(ds_i_instr[19:15]);
  assign rs2_d  = AWIDTH_REG'(ds_i_instr[24:20]);

  always_comb begin
    class_d = '0;
    imm32   = '0;
    case (opcode)
      7'b0110011: class_d[C_RALU]   = 1'b1;
      7'b0010011: begin class_d[C_IALU] = 1'b1; imm32 = {{20{s}}, ds_i_instr[31:20]}; end
      7'b0000011: begin class_d[C_LOAD] = 1'b1; imm32 = {{20{s}}, ds_i_instr[31:20]}; end
      7'b1100111: begin class_d[C_JALR] = 1'b1; imm32 = {{20{s}}, ds_i_instr[31:20]}; end
      7'b0100011: begin
        class_d[C_STORE] = 1'b1;
        imm32 = {{20{s}}, ds_i_instr[31:25], ds_i_instr[11:7]};
      end
      7'b1100011: begin
        class_d[C_BRANCH] = 1'b1;
        imm32 = {{19{s}}, ds_i_instr[31], ds_i_instr[7], ds_i_instr[30:25],
                 ds_i_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        class_d[C_JAL] = 1'b1;
        imm32 = {{11{s}}, ds_i_instr[31], ds_i_instr[19:12], ds_i_instr[20],
                 ds_i_instr[30:21], 1'b0};
      end
      7'b0110111: begin class_d[C_LUI]   = 1'b1; imm32 = {ds_i_instr[31:12], 12'b0}; end
      7'b0010111: begin class_d[C_AUIPC] = 1'b1; imm32 = {ds_i_instr[31:12], 12'b0}; end
      7'b1110011: class_d[C_SYSTEM] = 1'b1;
      7'b0001111: class_d[C_FENCE]  = 1'b1;
      default:    class_d = '0;
    endcase
    illegal_d = (ds_i_instr[1:0] != 2'b11) || (class_d == '0);
    // An illegal word carries no class and no immediate downstream.
    if (illegal_d) begin
      class_d = '0;
      imm32   = '0;
    end
    imm_d = DWIDTH'(imm32);
    rd_d  = (class_d[C_STORE] || class_d[C_BRANCH]) ? '0 : AWIDTH_REG'(ds_i_instr[11:7]);
  end

  assign rs1_used = (class_d != '0) &&
                    !(class_d[C_LUI] || class_d[C_AUIPC] || class_d[C_JAL] || class_d[C_FENCE]);
  assign rs2_used = class_d[C_RALU] || class_d[C_STORE] || class_d[C_BRANCH];

  assign hazard = ce_q && class_q[C_LOAD] && (rd_q != '0) && ds_i_ce &&
                  ((rs1_used && (rs1_d == rd_q)) || (rs2_used && (rs2_d == rd_q)));

  assign ds_o_stall = ds_i_stall || (hazard && !ds_i_flush);
  assign ds_o_flush = ds_i_flush;

  always_ff @(posedge ds_clk or posedge ds_rst) begin
    if (ds_rst) begin
      ce_q       <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
      class_q    <= '0;
      illegal_q  <= 1'b0;
    end else if (ds_i_flush) begin
      ce_q    <= 1'b0;
      class_q <= '0;
    end else if (ds_i_stall) begin
      ce_q <= ce_q;
    end else if (hazard) begin
      // Bubble: ce drops, so the hazard term is gone on the following cycle.
      ce_q <= 1'b0;
    end else if (ds_i_ce) begin
      ce_q       <= 1'b1;
      pc_q       <= ds_i_pc;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      imm_q      <= imm_d;
      funct3_q   <= ds_i_instr[14:12];
      funct7b5_q <= ds_i_instr[30];
      class_q    <= class_d;
      illegal_q  <= illegal_d;
    end else begin
      ce_q <= 1'b0;
    end
  end

  assign ds_o_ce       = ce_q;
  assign ds_o_pc       = pc_q;
  assign ds_o_rs1      = rs1_q;
  assign ds_o_rs2      = rs2_q;
  assign ds_o_rd       = rd_q;
  assign ds_o_imm      = imm_q;
  assign ds_o_funct3   = funct3_q;
  assign ds_o_funct7b5 = funct7b5_q;
  assign ds_o_class    = class_q;
  assign ds_o_illegal  = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded RV32I words with hand-computed
// decode results, load-use bubbles, flush/stall priority, illegal words and reset.
module tb_decode_stage;

  logic        ds_clk = 1'b0;
  logic        ds_rst;
  logic [31:0] ds_i_instr;
  logic [31:0] ds_i_pc;
  logic        ds_i_ce, ds_i_stall, ds_i_flush;
  logic        ds_o_stall, ds_o_flush, ds_o_ce;
  logic [31:0] ds_o_pc;
  logic [4:0]  ds_o_rs1, ds_o_rs2, ds_o_rd;
  logic [31:0] ds_o_imm;
  logic [2:0]  ds_o_funct3;
  logic        ds_o_funct7b5;
  logic [10:0] ds_o_class;
  logic        ds_o_illegal;

  int n_assert = 0;
  int n_fail   = 0;

  // Class one-hot values, bit 0 = RALU ... bit 10 = FENCE.
  localparam logic [31:0] K_RALU   = 32'h001;
  localparam logic [31:0] K_IALU   = 32'h002;
  localparam logic [31:0] K_LOAD   = 32'h004;
  localparam logic [31:0] K_STORE  = 32'h008;
  localparam logic [31:0] K_BRANCH = 32'h010;
  localparam logic [31:0] K_JAL    = 32'h020;
  localparam logic [31:0] K_LUI    = 32'h080;

  decode_stage dut (
    .ds_clk(ds_clk), .ds_rst(ds_rst),
    .ds_i_instr(ds_i_instr), .ds_i_pc(ds_i_pc), .ds_i_ce(ds_i_ce),
    .ds_i_stall(ds_i_stall), .ds_i_flush(ds_i_flush),
    .ds_o_stall(ds_o_stall), .ds_o_flush(ds_o_flush), .ds_o_ce(ds_o_ce),
    .ds_o_pc(ds_o_pc), .ds_o_rs1(ds_o_rs1), .ds_o_rs2(ds_o_rs2), .ds_o_rd(ds_o_rd),
    .ds_o_imm(ds_o_imm), .ds_o_funct3(ds_o_funct3), .ds_o_funct7b5(ds_o_funct7b5),
    .ds_o_class(ds_o_class), .ds_o_illegal(ds_o_illegal)
  );

  always #5 ds_clk = ~ds_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic ce, input logic stall, input logic flush);
    @(negedge ds_clk);
    ds_i_instr = instr;
    ds_i_pc    = pc;
    ds_i_ce    = ce;
    ds_i_stall = stall;
    ds_i_flush = flush;
    #1;
  endtask

  task automatic tick();
    @(posedge ds_clk);
    #1;
  endtask

  initial begin
    ds_rst = 1'b1;
    ds_i_instr = '0; ds_i_pc = '0; ds_i_ce = 1'b0; ds_i_stall = 1'b0; ds_i_flush = 1'b0;
    tick(); tick();
    chk("rst_ce", 32'(ds_o_ce), 0);
    chk("rst_class", 32'(ds_o_class), 0);
    chk("rst_imm", ds_o_imm, 0);
    chk("rst_pc", ds_o_pc, 0);
    chk("rst_stall", 32'(ds_o_stall), 0);
    @(negedge ds_clk);
    ds_rst = 1'b0;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100, 1, 0, 0); tick();
    chk("addi_ce", 32'(ds_o_ce), 1);
    chk("addi_rd", 32'(ds_o_rd), 1);
    chk("addi_rs1", 32'(ds_o_rs1), 0);
    chk("addi_imm", ds_o_imm, 32'd5);
    chk("addi_class", 32'(ds_o_class), K_IALU);
    chk("addi_pc", ds_o_pc, 32'h100);

    // beq x0,x0,-4
    drive(32'hFE000EE3, 32'h104, 1, 0, 0); tick();
    chk("beq_class", 32'(ds_o_class), K_BRANCH);
    chk("beq_rd", 32'(ds_o_rd), 0);
    chk("beq_imm", ds_o_imm, 32'hFFFFFFFC);

    // sw x5,-4(x1)
    drive(32'hFE50AE23, 32'h108, 1, 0, 0); tick();
    chk("sw_class", 32'(ds_o_class), K_STORE);
    chk("sw_rd", 32'(ds_o_rd), 0);
    chk("sw_rs1", 32'(ds_o_rs1), 1);
    chk("sw_rs2", 32'(ds_o_rs2), 5);
    chk("sw_imm", ds_o_imm, 32'hFFFFFFFC);
    chk("sw_f3", 32'(ds_o_funct3), 2);

    // sub x7,x1,x2
    drive(32'h402083B3, 32'h10C, 1, 0, 0); tick();
    chk("sub_class", 32'(ds_o_class), K_RALU);
    chk("sub_f7b5", 32'(ds_o_funct7b5), 1);
    chk("sub_rs2", 32'(ds_o_rs2), 2);
    chk("sub_rd", 32'(ds_o_rd), 7);
    chk("sub_imm", ds_o_imm, 0);

    // lui x2,0x12345
    drive(32'h12345137, 32'h110, 1, 0, 0); tick();
    chk("lui_class", 32'(ds_o_class), K_LUI);
    chk("lui_imm", ds_o_imm, 32'h12345000);
    chk("lui_rd", 32'(ds_o_rd), 2);

    // jal x1,+8
    drive(32'h008000EF, 32'h114, 1, 0, 0); tick();
    chk("jal_class", 32'(ds_o_class), K_JAL);
    chk("jal_imm", ds_o_imm, 32'd8);
    chk("jal_rd", 32'(ds_o_rd), 1);

    // lw x5,0(x1) followed by add x6,x5,x5: one bubble
    drive(32'h0000A283, 32'h118, 1, 0, 0); tick();
    chk("lw_class", 32'(ds_o_class), K_LOAD);
    chk("lw_rd", 32'(ds_o_rd), 5);
    drive(32'h00528333, 32'h11C, 1, 0, 0);
    chk("luse_stall", 32'(ds_o_stall), 1);
    tick();
    chk("bubble_ce", 32'(ds_o_ce), 0);
    chk("bubble_pc_hold", ds_o_pc, 32'h118);
    chk("bubble_stall_clr", 32'(ds_o_stall), 0);
    tick();
    chk("luse_add_ce", 32'(ds_o_ce), 1);
    chk("luse_add_rd", 32'(ds_o_rd), 6);
    chk("luse_add_pc", ds_o_pc, 32'h11C);

    // lw x0,0(x1) then add x6,x0,x0: no stall for an x0 destination
    drive(32'h0000A003, 32'h120, 1, 0, 0); tick();
    drive(32'h00000333, 32'h124, 1, 0, 0);
    chk("x0load_stall", 32'(ds_o_stall), 0);
    tick();
    chk("x0load_ce", 32'(ds_o_ce), 1);
    chk("x0load_pc", ds_o_pc, 32'h124);

    // flush wins over stall
    drive(32'h00500093, 32'h128, 1, 1, 1);
    chk("flush_out", 32'(ds_o_flush), 1);
    chk("flush_stall_out", 32'(ds_o_stall), 1);
    tick();
    chk("flush_ce", 32'(ds_o_ce), 0);
    chk("flush_class", 32'(ds_o_class), 0);
    chk("flush_pc_hold", ds_o_pc, 32'h124);
    chk("flush_rd_hold", 32'(ds_o_rd), 6);

    // stall for three cycles then resume
    drive(32'h00500093, 32'h128, 1, 0, 0); tick();
    chk("pre_stall_pc", ds_o_pc, 32'h128);
    drive(32'h402083B3, 32'h12C, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_out", 32'(ds_o_stall), 1);
      tick();
      chk("stall_pc_frozen", ds_o_pc, 32'h128);
      chk("stall_ce_frozen", 32'(ds_o_ce), 1);
      chk("stall_class_frozen", 32'(ds_o_class), K_IALU);
    end
    drive(32'h402083B3, 32'h12C, 1, 0, 0); tick();
    chk("resume_pc", ds_o_pc, 32'h12C);
    chk("resume_class", 32'(ds_o_class), K_RALU);
    chk("resume_rd", 32'(ds_o_rd), 7);

    // flush masks a pending hazard on the stall output
    drive(32'h0000A283, 32'h130, 1, 0, 0); tick();
    drive(32'h00528333, 32'h134, 1, 0, 1);
    chk("flush_haz_stall", 32'(ds_o_stall), 0);
    tick();
    chk("flush_haz_ce", 32'(ds_o_ce), 0);
    chk("flush_haz_class", 32'(ds_o_class), 0);

    // illegal word, then a legal capture clears it
    drive(32'h00000000, 32'h138, 1, 0, 0); tick();
    chk("ill_flag", 32'(ds_o_illegal), 1);
    chk("ill_class", 32'(ds_o_class), 0);
    chk("ill_ce", 32'(ds_o_ce), 1);
    drive(32'h00500093, 32'h13C, 1, 0, 0); tick();
    chk("ill_clear", 32'(ds_o_illegal), 0);
    chk("ill_clear_class", 32'(ds_o_class), K_IALU);

    // no valid input: ce drops, fields hold
    drive(32'h402083B3, 32'h140, 0, 0, 0); tick();
    chk("noce_ce", 32'(ds_o_ce), 0);
    chk("noce_pc_hold", ds_o_pc, 32'h13C);

    // reset asserted during a load-use hazard
    drive(32'h0000A283, 32'h144, 1, 0, 0); tick();
    drive(32'h00528333, 32'h148, 1, 0, 0);
    chk("rst_haz_pre", 32'(ds_o_stall), 1);
    ds_rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(ds_o_ce), 0);
    chk("midrst_class", 32'(ds_o_class), 0);
    chk("midrst_pc", ds_o_pc, 0);
    chk("midrst_rd", 32'(ds_o_rd), 0);
    chk("midrst_imm", ds_o_imm, 0);
    chk("midrst_stall", 32'(ds_o_stall), 0);
    tick();
    @(negedge ds_clk);
    ds_rst = 1'b0;
    tick();
    chk("postrst_ce", 32'(ds_o_ce), 1);
    chk("postrst_rd", 32'(ds_o_rd), 6);
    chk("postrst_pc", ds_o_pc, 32'h148);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
